// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Programmable video timing and test-pattern generator. Produces frame sync
// (fs), line sync (hs), a valid strobe and CHANNELS parallel pattern words
// per beat. Active/blank geometry is set by parameters. The pattern is
// selected at runtime and latched at each frame start.
// Downstream backpressure (ready) freezes the generator only while a pixel
// beat is being presented.
// Optional feature: define VPG_CHECKSUM_EN to build the per-frame checksum
// that drives frame_sum. Without it, frame_sum is tied to 0.
//
// Handshake: a beat is presented while valid=1 and transfers on a rising edge
// where valid=1 and ready=1. While valid=1 and ready=0 the counters and every
// output hold. While valid=0, ready is ignored and the timing advances.
module video_pattern_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int H_ACTIVE   = 32,
    parameter int H_BLANK    = 5,
    parameter int V_FRONT    = 1,
    parameter int V_ACTIVE   = 32,
    parameter int V_BACK     = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [1:0]                     mode,
    input  logic [DATA_WIDTH-1:0]          const_val,
    input  logic                           ready,
    output logic                           fs,
    output logic                           hs,
    output logic                           valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] data,
    output logic [11:0]                    x,
    output logic [11:0]                    y,
    output logic [15:0]                    frame_cnt,
    output logic [31:0]                    frame_sum
);

    // Counters carry two spare bits above the 12-bit geometry. The vertical
    // offset subtraction wraps into that headroom for lines above the active
    // region, so a single unsigned compare finds active lines.
    localparam int CW = 14;
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_BLANK - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_FRONT + V_ACTIVE + V_BACK - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_FIRST = CW'(V_FRONT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [CW-1:0]                  h_cnt;
    logic [CW-1:0]                  v_cnt;
    logic [CW-1:0]                  h_next;
    logic [CW-1:0]                  v_next;
    logic [CW-1:0]                  y_raw;
    logic                           at_h_last;
    logic                           at_last;
    logic                           at_origin;
    logic                           advance;
    logic                           line_act;
    logic                           pix_act;
    logic [11:0]                    x_pos;
    logic [11:0]                    y_pos;
    logic [1:0]                     mode_q;
    logic [1:0]                     mode_eff;
    logic [DATA_WIDTH-1:0]          const_q;
    logic [DATA_WIDTH-1:0]          const_eff;
    logic [CHANNELS*DATA_WIDTH-1:0] pix_data;

    // Position decode for the current counter values.
    always_comb begin
        at_h_last = (h_cnt == H_LAST);
        at_last   = at_h_last && (v_cnt == V_LAST);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        advance   = !(valid && !ready);
        y_raw     = v_cnt - V_FIRST;
        line_act  = (y_raw < V_ACT);
        pix_act   = line_act && (h_cnt < H_ACT);
        x_pos     = pix_act ? h_cnt[11:0] : 12'd0;
        y_pos     = line_act ? y_raw[11:0] : 12'd0;
        // The first pixel of a frame must already use the newly sampled settings.
        mode_eff  = at_origin ? mode : mode_q;
        const_eff = at_origin ? const_val : const_q;
    end

    // FSM next state and raster counter next values.
    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (at_last && !en) begin
                    state_next = IDLE;
                end
                if (at_h_last) begin
                    h_next = '0;
                    v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_next = h_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pattern words for the pixel at the current counter position.
    always_comb begin
        pix_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode_eff)
                2'd0:    pix_data[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(x_pos) + DATA_WIDTH'(y_pos) + DATA_WIDTH'(c);
                2'd1:    pix_data[c*DATA_WIDTH +: DATA_WIDTH] = const_eff;
                2'd2:    pix_data[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{x_pos[3] ^ y_pos[3]}};
                default: pix_data[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(frame_cnt) + DATA_WIDTH'(c);
            endcase
        end
    end

    // State register and raster counters. Everything freezes during a stalled beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Pattern settings are sampled once per frame, at the frame origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 2'd0;
            const_q <= '0;
        end else if (advance && at_origin) begin
            mode_q  <= mode;
            const_q <= const_val;
        end
    end

    // Registered outputs: one cycle behind the counter position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs    <= 1'b0;
            hs    <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
            x     <= 12'd0;
            y     <= 12'd0;
        end else if (advance) begin
            if (state == RUN) begin
                fs    <= line_act;
                hs    <= pix_act;
                valid <= pix_act;
                data  <= pix_act ? pix_data : '0;
                x     <= x_pos;
                y     <= y_pos;
            end else begin
                fs    <= 1'b0;
                hs    <= 1'b0;
                valid <= 1'b0;
                data  <= '0;
                x     <= 12'd0;
                y     <= 12'd0;
            end
        end
    end

    // Completed-frame counter: bumps when leaving the last raster position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (state == RUN && advance && at_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef VPG_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] beat_sum;
    logic        beat_take;
    logic        last_beat;

    // Sum of all channel words of the beat currently presented.
    always_comb begin
        beat_sum = 32'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            beat_sum = beat_sum + 32'(data[c*DATA_WIDTH +: DATA_WIDTH]);
        end
        beat_take = valid && ready;
        last_beat = beat_take && (x == 12'(H_ACTIVE - 1)) && (y == 12'(V_ACTIVE - 1));
    end

    // Accumulate accepted beats. Publish the total as the last beat transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 32'd0;
            frame_sum <= 32'd0;
        end else begin
            if (state == IDLE || at_origin) begin
                acc <= 32'd0;
            end else if (beat_take) begin
                acc <= acc + beat_sum;
            end
            if (last_beat) begin
                frame_sum <= acc + beat_sum;
            end
        end
    end
`else
    assign frame_sum = 32'd0;
`endif

endmodule
